// File: rtl/usb_tx_data_buffer_if.sv
// Byte-stream interface between the AHB slave / protocol controller and the usb_tx data buffer.
// Carries write and pop strobes, the show-ahead head byte, and occupancy/status back to the writer.
// master = the clients that write and pop bytes; slave = the buffer itself.
interface usb_tx_data_buffer_if #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 8
);
   localparam int OW = $clog2(DEPTH) + 1;

   logic             flush;
   logic             store_tx_data;
   logic [WIDTH-1:0] tx_data;
   logic             get_tx_packet_data;
   logic [WIDTH-1:0] tx_packet_data;
   logic [OW-1:0]    buffer_occupancy;
   logic             buffer_empty;
   logic             buffer_full;
   logic             buffer_error;

   modport master (
      output flush,
      output store_tx_data,
      output tx_data,
      output get_tx_packet_data,
      input  tx_packet_data,
      input  buffer_occupancy,
      input  buffer_empty,
      input  buffer_full,
      input  buffer_error
   );

   modport slave (
      input  flush,
      input  store_tx_data,
      input  tx_data,
      input  get_tx_packet_data,
      output tx_packet_data,
      output buffer_occupancy,
      output buffer_empty,
      output buffer_full,
      output buffer_error
   );
endinterface

// File: rtl/usb_tx_data_buffer.sv
// Byte FIFO feeding usb_tx from the AHB slave; head byte is show-ahead, occupancy kept as its own counter.
// Latency: a written byte is visible at tx_packet_data the cycle after its write edge; flags decode registered occupancy.
// Backpressure: none; writes when full are dropped and pops when empty are ignored, optionally latched as a sticky
// error when TX_BUF_ERR_EN is defined (otherwise buffer_error is tied low).
module usb_tx_data_buffer #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   usb_tx_data_buffer_if.slave     bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;

   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [OW-1:0] OCC_ONE  = OW'(1);
   localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [OW-1:0]    occupancy;
   logic             empty;
   logic             full;
   logic             wr_ok;
   logic             rd_ok;

   assign empty = (occupancy == '0);
   assign full  = (occupancy == OCC_FULL);

   // A write into a full buffer is still taken when a pop frees the head slot in the same edge;
   // a pop on an empty buffer is never taken, even if a write lands in the same edge.
   assign wr_ok = bus.store_tx_data && (!full || bus.get_tx_packet_data) && !bus.flush;
   assign rd_ok = bus.get_tx_packet_data && !empty && !bus.flush;

   // Storage write; contents need no reset because occupancy gates what is visible.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= bus.tx_data;
      end
   end

   // Pointers and occupancy counter; flush discards everything but leaves the error flag alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else if (bus.flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({wr_ok, rd_ok})
            2'b10:   occupancy <= occupancy + OCC_ONE;
            2'b01:   occupancy <= occupancy - OCC_ONE;
            default: occupancy <= occupancy;
         endcase
      end
   end

`ifdef TX_BUF_ERR_EN
   logic overflow;
   logic underflow;
   logic error;

   // Events are masked by flush so a discarded strobe never counts as misuse.
   assign overflow  = bus.store_tx_data && full && !bus.get_tx_packet_data && !bus.flush;
   assign underflow = bus.get_tx_packet_data && empty && !bus.flush;

   // Sticky error: only rst clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         error <= 1'b0;
      end else if (overflow || underflow) begin
         error <= 1'b1;
      end
   end

   assign bus.buffer_error = error;
`else
   assign bus.buffer_error = 1'b0;
`endif

   assign bus.tx_packet_data   = empty ? '0 : mem[rd_ptr];
   assign bus.buffer_occupancy = occupancy;
   assign bus.buffer_empty     = empty;
   assign bus.buffer_full      = full;

endmodule

// File: tb/tb_usb_tx_data_buffer.sv
// Directed bench for usb_tx_data_buffer: a queue model of the byte stream is checked every negedge,
// and literal expectations at key points pin the model. Works with or without TX_BUF_ERR_EN.
module tb_usb_tx_data_buffer;
   localparam int DEPTH = 64;
   localparam int WIDTH = 8;
`ifdef TX_BUF_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   usb_tx_data_buffer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

   usb_tx_data_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: the buffer contents as an ordered byte queue plus a sticky error bit.
   logic [7:0] q[$];
   bit         m_err = 1'b0;
   bit         model_valid = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit st, input logic [7:0] d, input bit gt, input bit fl, input bit r);
      bit was_full;
      bit was_empty;
      if (r) begin
         q.delete();
         m_err = 1'b0;
      end else if (fl) begin
         q.delete();
      end else begin
         was_full  = (q.size() == DEPTH);
         was_empty = (q.size() == 0);
         if (ERR_EN && ((st && was_full && !gt) || (gt && was_empty))) m_err = 1'b1;
         if (gt && !was_empty) void'(q.pop_front());
         if (st && (!was_full || gt)) q.push_back(d);
      end
      model_valid = 1'b1;
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, settle 2 time units past the edge.
   task automatic cyc(input bit st, input logic [7:0] d, input bit gt, input bit fl, input bit r);
      bus.store_tx_data      = st;
      bus.tx_data            = d;
      bus.get_tx_packet_data = gt;
      bus.flush              = fl;
      rst                    = r;
      @(posedge clk);
      model_step(st, d, gt, fl, r);
      #2;
   endtask

   // Per-cycle comparison of every output against the queue model.
   always @(negedge clk) begin
      if (model_valid) begin
         chk("occupancy", int'(bus.buffer_occupancy), q.size());
         chk("empty", int'(bus.buffer_empty), int'(q.size() == 0));
         chk("full", int'(bus.buffer_full), int'(q.size() == DEPTH));
         chk("head", int'(bus.tx_packet_data), (q.size() != 0) ? int'(q[0]) : 0);
         chk("error", int'(bus.buffer_error), int'(m_err));
      end
   end

   initial begin
      bus.store_tx_data      = 1'b0;
      bus.tx_data            = '0;
      bus.get_tx_packet_data = 1'b0;
      bus.flush              = 1'b0;

      // Reset for two cycles.
      cyc(0, 8'h00, 0, 0, 1);
      cyc(0, 8'h00, 0, 0, 1);
      cyc(0, 8'h00, 0, 0, 0);
      chk("rst_occ", int'(bus.buffer_occupancy), 0);
      chk("rst_empty", int'(bus.buffer_empty), 1);
      chk("rst_full", int'(bus.buffer_full), 0);
      chk("rst_data", int'(bus.tx_packet_data), 8'h00);
      chk("rst_err", int'(bus.buffer_error), 0);

      // Single byte in and out.
      cyc(1, 8'hAA, 0, 0, 0);
      chk("single_data", int'(bus.tx_packet_data), 8'hAA);
      chk("single_occ", int'(bus.buffer_occupancy), 1);
      cyc(0, 8'h00, 1, 0, 0);
      chk("single_pop_occ", int'(bus.buffer_occupancy), 0);
      chk("single_pop_empty", int'(bus.buffer_empty), 1);
      chk("single_pop_data", int'(bus.tx_packet_data), 8'h00);

      // Fill completely.
      for (int i = 0; i < 64; i++) cyc(1, 8'(i), 0, 0, 0);
      chk("fill_full", int'(bus.buffer_full), 1);
      chk("fill_occ", int'(bus.buffer_occupancy), 64);

      // Overflow: dropped byte, head unchanged.
      cyc(1, 8'hFF, 0, 0, 0);
      chk("ovf_occ", int'(bus.buffer_occupancy), 64);
      chk("ovf_head", int'(bus.tx_packet_data), 8'h00);
      chk("ovf_err", int'(bus.buffer_error), int'(ERR_EN));

      // Pop 32, refill past the wrap point, drain and check order.
      for (int i = 0; i < 32; i++) begin
         chk("pop_first_half", int'(bus.tx_packet_data), i);
         cyc(0, 8'h00, 1, 0, 0);
      end
      for (int i = 0; i < 32; i++) cyc(1, 8'(8'h40 + i), 0, 0, 0);
      chk("wrap_occ", int'(bus.buffer_occupancy), 64);
      for (int i = 0; i < 64; i++) begin
         chk("wrap_order", int'(bus.tx_packet_data), 8'h20 + i);
         cyc(0, 8'h00, 1, 0, 0);
      end
      chk("wrap_empty", int'(bus.buffer_empty), 1);

      // Simultaneous write and pop at occupancy 3.
      cyc(0, 8'h00, 0, 0, 1);
      cyc(1, 8'hA1, 0, 0, 0);
      cyc(1, 8'hA2, 0, 0, 0);
      cyc(1, 8'hA3, 0, 0, 0);
      cyc(1, 8'hA4, 1, 0, 0);
      chk("simul_occ", int'(bus.buffer_occupancy), 3);
      for (int i = 0; i < 3; i++) begin
         chk("simul_order", int'(bus.tx_packet_data), 8'hA2 + i);
         cyc(0, 8'h00, 1, 0, 0);
      end
      chk("simul_err_clean", int'(bus.buffer_error), 0);

      // Write with pop on empty: write taken, pop is an underflow.
      cyc(1, 8'h7E, 1, 0, 0);
      chk("empty_wp_occ", int'(bus.buffer_occupancy), 1);
      chk("empty_wp_data", int'(bus.tx_packet_data), 8'h7E);
      chk("empty_wp_err", int'(bus.buffer_error), int'(ERR_EN));

      // Full with write and pop: both taken, occupancy stays at DEPTH.
      cyc(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 64; i++) cyc(1, 8'(8'h80 + i), 0, 0, 0);
      cyc(1, 8'hC0, 1, 0, 0);
      chk("full_wp_occ", int'(bus.buffer_occupancy), 64);
      chk("full_wp_head", int'(bus.tx_packet_data), 8'h81);
      chk("full_wp_err", int'(bus.buffer_error), 0);

      // Flush with 10 stored and a concurrent write; strobes under flush raise no error.
      cyc(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 10; i++) cyc(1, 8'(8'h50 + i), 0, 0, 0);
      cyc(1, 8'hEE, 0, 1, 0);
      chk("flush_occ", int'(bus.buffer_occupancy), 0);
      chk("flush_empty", int'(bus.buffer_empty), 1);
      cyc(0, 8'h00, 1, 1, 0);
      chk("flush_pop_err", int'(bus.buffer_error), 0);
      cyc(1, 8'h11, 0, 0, 0);
      chk("flush_next", int'(bus.tx_packet_data), 8'h11);
      chk("flush_next_occ", int'(bus.buffer_occupancy), 1);

      // Underflow sets error; a later flush keeps it.
      cyc(0, 8'h00, 1, 0, 0);
      cyc(0, 8'h00, 1, 0, 0);
      chk("unf_err", int'(bus.buffer_error), int'(ERR_EN));
      cyc(1, 8'h22, 0, 1, 0);
      chk("flush_keeps_err", int'(bus.buffer_error), int'(ERR_EN));

      // Reset while usb_tx is still popping; later pops underflow.
      for (int i = 0; i < 3; i++) cyc(1, 8'(8'h30 + i), 0, 0, 0);
      cyc(0, 8'h00, 1, 0, 1);
      chk("midrst_occ", int'(bus.buffer_occupancy), 0);
      chk("midrst_err", int'(bus.buffer_error), 0);
      cyc(0, 8'h00, 1, 0, 0);
      cyc(0, 8'h00, 1, 0, 0);
      chk("midrst_unf_err", int'(bus.buffer_error), int'(ERR_EN));
      chk("midrst_data", int'(bus.tx_packet_data), 8'h00);

      cyc(0, 8'h00, 0, 0, 0);
      cyc(0, 8'h00, 0, 0, 0);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/usb_tx_data_buffer.md
Name: usb_tx_data_buffer

Overview:
- 64-byte transmit data FIFO between the AHB-Lite slave (writer) and usb_tx (reader).
- The AHB slave pushes payload bytes before the protocol controller issues tx_packet = DATA.
- usb_tx pops one byte per get_tx_packet_data pulse and serialises it behind SYNC/PID, ahead of CRC16/EOP.
- The block also reports occupancy to the AHB slave, which uses it for tx_packet_data_size and status.

Parameters:
- DEPTH, 64, number of byte entries; must be a power of two, minimum 4.
- WIDTH, 8, bits per entry.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  protocol-controller request to discard all contents.
- store_tx_data  input  1  write strobe from the AHB slave, one byte per cycle high.
- tx_data  input  WIDTH  byte to write.
- get_tx_packet_data  input  1  pop strobe from usb_tx, one byte per cycle high.
- tx_packet_data  output  WIDTH  current head byte (show-ahead).
- buffer_occupancy  output  $clog2(DEPTH)+1  number of valid bytes, 0..DEPTH.
- buffer_empty  output  1  occupancy == 0.
- buffer_full  output  1  occupancy == DEPTH.
- buffer_error  output  1  sticky overflow/underflow flag; see Optional Feature.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - wr_ptr=0, rd_ptr=0, occupancy=0, error=0.
  - tx_packet_data=0, buffer_empty=1, buffer_full=0, buffer_error=0.
  - Storage array contents are don't-care.
- Storage and pointers:
  - Register array, DEPTH x WIDTH.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Occupancy is a separate up/down counter, not derived from the pointers.
- Write: store_tx_data=1 and not full → mem[wr_ptr] <= tx_data, wr_ptr+1, occupancy+1 at the edge.
- Read:
  - tx_packet_data = mem[rd_ptr] combinationally whenever occupancy>0; it is 0 when empty.
  - get_tx_packet_data=1 and not empty → rd_ptr+1, occupancy-1 at the edge.
  - The next byte is visible in the cycle after the pop edge.
- Status flags: buffer_empty and buffer_full are decoded from the registered occupancy, so there is zero added latency.
- Simultaneous write and pop:
  - Not empty and not full: both occur and occupancy is unchanged.
  - Empty: the write is accepted and the pop is ignored (underflow). The new byte becomes visible next cycle.
  - Full: both are accepted and occupancy stays DEPTH.
- Write when full: data dropped; pointers and occupancy unchanged; overflow event.
- Pop when empty: no pointer change; tx_packet_data stays 0; underflow event.
- Flush:
  - Priority is rst > flush > write/pop.
  - Flush clears wr_ptr, rd_ptr and occupancy in one cycle.
  - A write or pop in the same cycle is ignored and is not counted as an error.
  - Flush does not clear buffer_error.
- Reset mid-packet (usb_tx still requesting): the buffer empties immediately; later pops are underflow events.
- There is no internal state machine beyond the pointer/counter; all outputs are registered state or a direct decode of it.

Optional Feature:
- Macro TX_BUF_ERR_EN.
- Defined:
  - buffer_error is set at the edge following any overflow or underflow event.
  - It then stays 1 until rst.
  - A one-cycle error_clear is not provided; software resets the block via rst.
- Undefined:
  - No error logic is synthesised and buffer_error is tied to 0.
  - The port remains so instantiation is unchanged.

Test Plan:
- Reset: assert rst 2 cycles → occupancy=0, buffer_empty=1, buffer_full=0, tx_packet_data=8'h00, buffer_error=0.
- Single byte: write 8'hAA, then pulse get_tx_packet_data.
  - Cycle after write: tx_packet_data=8'hAA, occupancy=1.
  - After pop: occupancy=0, buffer_empty=1, tx_packet_data=8'h00.
- Order and wrap-around:
  - Write 64 bytes 8'h00..8'h3F → buffer_full=1, occupancy=64.
  - Pop 32, then write 8'h40..8'h5F.
  - Pop all → output sequence 8'h20..8'h5F in order, final buffer_empty=1.
- Overflow:
  - When full, write 8'hFF → occupancy stays 64 and the head byte is unchanged.
  - buffer_error=1 with TX_BUF_ERR_EN, and 0 without.
- Simultaneous events:
  - At occupancy=3, write and pop in the same cycle → occupancy stays 3 and order is preserved.
  - At empty, write 8'h7E with pop → occupancy=1, tx_packet_data=8'h7E, underflow flagged (with the macro).
- Flush:
  - With 10 bytes stored, assert flush together with store_tx_data → occupancy=0 and the write is discarded.
  - buffer_error is unchanged.
  - The next write of 8'h11 appears at tx_packet_data.
